// File: rtl/acc_pkg.sv
// Shared types and constants for the hash accelerator control unit.
package acc_pkg;

    localparam int unsigned ACC_ADDR_W  = 16;
    localparam int unsigned ACC_WORD_W  = 32;

    // Default memory map
    localparam logic [ACC_ADDR_W-1:0] ACC_HCB_START_ADDR = 16'h1000;
    localparam logic [ACC_ADDR_W-1:0] ACC_ACB_START_ADDR = 16'h5000;
    localparam logic [ACC_ADDR_W-1:0] ACC_ACB_H0_OFFSET  = 16'h0008;

    // Status word bit positions
    localparam int unsigned STATUS_START_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT  = 1;
    localparam int unsigned STATUS_BUSY_BIT  = 2;

    // Status words written back by the unit
    localparam logic [ACC_WORD_W-1:0] STATUS_BUSY_WORD =
        (ACC_WORD_W'(1) << STATUS_START_BIT) | (ACC_WORD_W'(1) << STATUS_BUSY_BIT);
    localparam logic [ACC_WORD_W-1:0] STATUS_DONE_WORD =
        (ACC_WORD_W'(1) << STATUS_DONE_BIT);

    // WRITE_H0..WRITE_H7 and WRITE_DONE_BIT are consecutive so the
    // digest-write sequence advances by simple increment.
    typedef enum logic [3:0] {
        IDLE           = 4'd0,
        READ_MESSAGE   = 4'd1,
        WRITE_BUSY_BIT = 4'd2,
        INIT           = 4'd3,
        HASH           = 4'd4,
        WRITE_H0       = 4'd5,
        WRITE_H1       = 4'd6,
        WRITE_H2       = 4'd7,
        WRITE_H3       = 4'd8,
        WRITE_H4       = 4'd9,
        WRITE_H5       = 4'd10,
        WRITE_H6       = 4'd11,
        WRITE_H7       = 4'd12,
        WRITE_DONE_BIT = 4'd13
    } state_t;

    // Digest word index of a WRITE_Hi state (meaningless in other states).
    function automatic logic [2:0] h_index(input state_t s);
        return 3'(4'(s) - 4'(WRITE_H0));
    endfunction

endpackage

// File: rtl/acc_hash_counter.sv
// Counts cycles spent in the HASH state; done flags the final HASH cycle.
module acc_hash_counter #(
    parameter int unsigned HASH_CYCLE_COUNT = 65
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(HASH_CYCLE_COUNT + 1);

    logic [CNT_W-1:0] r_count;

    // Cycle counter: cleared on reset or clear, advances while enabled
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign done = enable && (r_count == CNT_W'(HASH_CYCLE_COUNT - 1));

endmodule

// File: rtl/acc_control_unit.sv
// Hash accelerator control unit: snoops CPU writes for a START command,
// sequences message read, busy flag, hash run, digest write-back and done flag.
// Optional macro ACC_CU_ASSERT_EN compiles in protocol/state assertions.
module acc_control_unit
    import acc_pkg::*;
#(
    parameter int unsigned MEM_LISTEN_ADDR_SIZE    = 16,
    parameter int unsigned MEM_LISTEN_DATA_SIZE    = 32,
    parameter int unsigned MEM_ACC_READ_ADDR_SIZE  = 16,
    parameter int unsigned MEM_ACC_READ_DATA_SIZE  = 512,
    parameter int unsigned MEM_ACC_WRITE_ADDR_SIZE = 16,
    parameter int unsigned MEM_ACC_WRITE_DATA_SIZE = 32,
    parameter logic [15:0] HCB_START_ADDR          = ACC_HCB_START_ADDR,
    parameter logic [15:0] ACB_START_ADDR          = ACC_ACB_START_ADDR,
    parameter logic [15:0] ACB_H0_OFFSET           = ACC_ACB_H0_OFFSET,
    parameter int unsigned HASH_RESULT_LENGTH      = 256,
    parameter int unsigned HASH_CYCLE_COUNT        = 65
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mem_listen_en,
    input  logic [MEM_LISTEN_ADDR_SIZE-1:0]    mem_listen_addr,
    input  logic [MEM_LISTEN_DATA_SIZE-1:0]    mem_listen_data,
    output logic                               mem_acc_read_en,
    output logic [MEM_ACC_READ_ADDR_SIZE-1:0]  mem_acc_read_addr,
    input  logic                               mem_acc_read_data_valid,
    input  logic [MEM_ACC_READ_DATA_SIZE-1:0]  mem_acc_read_data,
    output logic                               mem_acc_write_en,
    output logic [MEM_ACC_WRITE_ADDR_SIZE-1:0] mem_acc_write_addr,
    output logic [MEM_ACC_WRITE_DATA_SIZE-1:0] mem_acc_write_data,
    input  logic                               mem_acc_write_done,
    input  logic [HASH_RESULT_LENGTH-1:0]      cm_out,
    output logic                               ms_init,
    output logic                               ms_enable,
    output logic                               cm_init,
    output logic                               cm_enable
);

    state_t       curr_state;
    logic         w_trigger;
    logic         w_hash_done;
    logic [2:0]   w_h_idx;
    logic [7:0]   w_h_base;
    logic [15:0]  w_h_addr;
    logic [31:0]  w_h_word;
    logic         w_unused;

    // The message block itself is consumed by the datapath, not here
    assign w_unused = ^{mem_acc_read_data, mem_listen_data[MEM_LISTEN_DATA_SIZE-1:1]};

    assign w_trigger = mem_listen_en
                    && (mem_listen_addr == MEM_LISTEN_ADDR_SIZE'(ACB_START_ADDR))
                    && mem_listen_data[STATUS_START_BIT];

    assign w_h_idx  = h_index(curr_state);
    assign w_h_base = {w_h_idx, 5'd0};
    assign w_h_addr = ACB_START_ADDR + ACB_H0_OFFSET + {8'd0, w_h_base};
    assign w_h_word = cm_out[w_h_base +: 32];

    acc_hash_counter #(
        .HASH_CYCLE_COUNT (HASH_CYCLE_COUNT)
    ) u_hash_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (curr_state == INIT),
        .enable (curr_state == HASH),
        .done   (w_hash_done)
    );

    // State sequencing; each request state waits for its completion strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_state <= IDLE;
        end else begin
            case (curr_state)
                IDLE:           if (w_trigger)               curr_state <= READ_MESSAGE;
                READ_MESSAGE:   if (mem_acc_read_data_valid) curr_state <= WRITE_BUSY_BIT;
                WRITE_BUSY_BIT: if (mem_acc_write_done)      curr_state <= INIT;
                INIT:                                        curr_state <= HASH;
                HASH:           if (w_hash_done)             curr_state <= WRITE_H0;
                WRITE_H0, WRITE_H1, WRITE_H2, WRITE_H3,
                WRITE_H4, WRITE_H5, WRITE_H6, WRITE_H7:
                    if (mem_acc_write_done) curr_state <= state_t'(4'(curr_state) + 4'd1);
                WRITE_DONE_BIT: if (mem_acc_write_done)      curr_state <= IDLE;
                default:                                     curr_state <= IDLE;
            endcase
        end
    end

    // Moore output decode from the state register; digest words pass straight through
    always_comb begin
        mem_acc_read_en    = 1'b0;
        mem_acc_read_addr  = '0;
        mem_acc_write_en   = 1'b0;
        mem_acc_write_addr = '0;
        mem_acc_write_data = '0;
        ms_init            = 1'b0;
        ms_enable          = 1'b0;
        cm_init            = 1'b0;
        cm_enable          = 1'b0;
        case (curr_state)
            READ_MESSAGE: begin
                mem_acc_read_en   = 1'b1;
                mem_acc_read_addr = MEM_ACC_READ_ADDR_SIZE'(HCB_START_ADDR);
            end
            WRITE_BUSY_BIT: begin
                mem_acc_write_en   = 1'b1;
                mem_acc_write_addr = MEM_ACC_WRITE_ADDR_SIZE'(ACB_START_ADDR);
                mem_acc_write_data = MEM_ACC_WRITE_DATA_SIZE'(STATUS_BUSY_WORD);
            end
            INIT: begin
                ms_init = 1'b1;
                cm_init = 1'b1;
            end
            HASH: begin
                ms_enable = 1'b1;
                cm_enable = 1'b1;
            end
            WRITE_H0, WRITE_H1, WRITE_H2, WRITE_H3,
            WRITE_H4, WRITE_H5, WRITE_H6, WRITE_H7: begin
                mem_acc_write_en   = 1'b1;
                mem_acc_write_addr = MEM_ACC_WRITE_ADDR_SIZE'(w_h_addr);
                mem_acc_write_data = MEM_ACC_WRITE_DATA_SIZE'(w_h_word);
            end
            WRITE_DONE_BIT: begin
                mem_acc_write_en   = 1'b1;
                mem_acc_write_addr = MEM_ACC_WRITE_ADDR_SIZE'(ACB_START_ADDR);
                mem_acc_write_data = MEM_ACC_WRITE_DATA_SIZE'(STATUS_DONE_WORD);
            end
            default: ;
        endcase
    end

`ifdef ACC_CU_ASSERT_EN
    int unsigned r_hash_dwell;

    // Independent HASH dwell tracker used only by the checks below
    always_ff @(posedge clk) begin
        if (rst || (curr_state != HASH)) begin
            r_hash_dwell <= 0;
        end else begin
            r_hash_dwell <= r_hash_dwell + 1;
        end
    end

    a_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(mem_acc_read_en && mem_acc_write_en));

    a_hash_dwell: assert property (@(posedge clk) disable iff (rst)
        (curr_state == HASH) |-> (w_hash_done == (r_hash_dwell == HASH_CYCLE_COUNT - 1)));

    a_legal_state: assert property (@(posedge clk) disable iff (rst)
        curr_state inside {IDLE, READ_MESSAGE, WRITE_BUSY_BIT, INIT, HASH,
                           WRITE_H0, WRITE_H1, WRITE_H2, WRITE_H3,
                           WRITE_H4, WRITE_H5, WRITE_H6, WRITE_H7, WRITE_DONE_BIT});
`endif

endmodule

// File: tb/tb_acc_control_unit.sv
// Directed bench for acc_control_unit: trigger filtering, full hash sequence,
// digest write-back and mid-operation reset.
module tb_acc_control_unit;
    import acc_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_listen_en;
    logic [15:0]  mem_listen_addr;
    logic [31:0]  mem_listen_data;
    logic         mem_acc_read_en;
    logic [15:0]  mem_acc_read_addr;
    logic         mem_acc_read_data_valid;
    logic [511:0] mem_acc_read_data;
    logic         mem_acc_write_en;
    logic [15:0]  mem_acc_write_addr;
    logic [31:0]  mem_acc_write_data;
    logic         mem_acc_write_done;
    logic [255:0] cm_out;
    logic         ms_init, ms_enable, cm_init, cm_enable;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    acc_control_unit dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_listen_en           (mem_listen_en),
        .mem_listen_addr         (mem_listen_addr),
        .mem_listen_data         (mem_listen_data),
        .mem_acc_read_en         (mem_acc_read_en),
        .mem_acc_read_addr       (mem_acc_read_addr),
        .mem_acc_read_data_valid (mem_acc_read_data_valid),
        .mem_acc_read_data       (mem_acc_read_data),
        .mem_acc_write_en        (mem_acc_write_en),
        .mem_acc_write_addr      (mem_acc_write_addr),
        .mem_acc_write_data      (mem_acc_write_data),
        .mem_acc_write_done      (mem_acc_write_done),
        .cm_out                  (cm_out),
        .ms_init                 (ms_init),
        .ms_enable               (ms_enable),
        .cm_init                 (cm_init),
        .cm_enable               (cm_enable)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_state"}, 256'(dut.curr_state), 256'(IDLE));
        chk({tag, "_rd_en"}, 256'(mem_acc_read_en), 256'(0));
        chk({tag, "_rd_addr"}, 256'(mem_acc_read_addr), 256'(0));
        chk({tag, "_wr_en"}, 256'(mem_acc_write_en), 256'(0));
        chk({tag, "_wr_addr"}, 256'(mem_acc_write_addr), 256'(0));
        chk({tag, "_wr_data"}, 256'(mem_acc_write_data), 256'(0));
        chk({tag, "_ctl"}, 256'({ms_init, ms_enable, cm_init, cm_enable}), 256'(0));
    endtask

    task automatic trigger_to_hash();
        mem_listen_en = 1'b1; mem_listen_addr = 16'h5000; mem_listen_data = 32'h1;
        tick();
        mem_listen_en = 1'b0;
        mem_acc_read_data_valid = 1'b1;
        tick();
        mem_acc_read_data_valid = 1'b0;
        mem_acc_write_done = 1'b1;
        tick();
        mem_acc_write_done = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] exp_w [8];
        logic [31:0] new_word;
        int          hash_cycles;

        rst = 1'b1;
        mem_listen_en = 1'b1; mem_listen_addr = 16'h5000; mem_listen_data = 32'h1;
        mem_acc_read_data_valid = 1'b0;
        mem_acc_read_data = '0;
        mem_acc_write_done = 1'b0;
        cm_out = '0;

        // Reset with a trigger present: must stay idle
        tick();
        tick();
        chk_quiet("reset");
        mem_listen_en = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_reset_idle", 256'(dut.curr_state), 256'(IDLE));

        // Non-trigger writes
        mem_listen_en = 1'b1; mem_listen_addr = 16'h5004; mem_listen_data = 32'h1;
        tick();
        chk("wrong_addr", 256'(dut.curr_state), 256'(IDLE));
        mem_listen_addr = 16'h5000; mem_listen_data = 32'h0;
        tick();
        chk("data_zero", 256'(dut.curr_state), 256'(IDLE));
        mem_listen_en = 1'b0; mem_listen_data = 32'h1;
        tick();
        chk("en_low", 256'(dut.curr_state), 256'(IDLE));

        // Trigger
        mem_listen_en = 1'b1;
        tick();
        mem_listen_en = 1'b0;
        chk("rm_state", 256'(dut.curr_state), 256'(READ_MESSAGE));
        chk("rm_rd_en", 256'(mem_acc_read_en), 256'(1));
        chk("rm_rd_addr", 256'(mem_acc_read_addr), 256'(16'h1000));
        chk("rm_wr_en", 256'(mem_acc_write_en), 256'(0));

        // Stray write_done and listener activity outside IDLE are ignored
        mem_acc_write_done = 1'b1;
        mem_listen_en = 1'b1;
        tick();
        mem_acc_write_done = 1'b0;
        mem_listen_en = 1'b0;
        chk("rm_hold", 256'(dut.curr_state), 256'(READ_MESSAGE));

        mem_acc_read_data_valid = 1'b1;
        tick();
        mem_acc_read_data_valid = 1'b0;
        chk("busy_state", 256'(dut.curr_state), 256'(WRITE_BUSY_BIT));
        chk("busy_wr", 256'({mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data}),
            256'({1'b1, 16'h5000, 32'h5}));
        chk("busy_rd_en", 256'(mem_acc_read_en), 256'(0));
        tick();
        chk("busy_hold", 256'(dut.curr_state), 256'(WRITE_BUSY_BIT));

        mem_acc_write_done = 1'b1;
        tick();
        mem_acc_write_done = 1'b0;
        chk("init_state", 256'(dut.curr_state), 256'(INIT));
        chk("init_ctl", 256'({ms_init, ms_enable, cm_init, cm_enable}), 256'(4'b1010));

        for (int i = 0; i < 8; i++) begin
            exp_w[i] = $urandom;
            cm_out[32*i +: 32] = exp_w[i];
        end

        tick();
        chk("hash_ctl", 256'({ms_init, ms_enable, cm_init, cm_enable}), 256'(4'b0101));
        hash_cycles = 0;
        while ((dut.curr_state == HASH) && (hash_cycles < 200)) begin
            hash_cycles++;
            tick();
        end
        chk("hash_dwell", 256'(hash_cycles), 256'(65));
        chk("h0_entry", 256'(dut.curr_state), 256'(WRITE_H0));

        // Digest write-back
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("h%0d_state", i), 256'(dut.curr_state), 256'(5 + i));
            chk($sformatf("h%0d_wr", i),
                256'({mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data}),
                256'({1'b1, 16'(16'h5008 + 32 * i), exp_w[i]}));
            if (i == 3) begin
                new_word = $urandom;
                exp_w[3] = ~new_word;
                cm_out[96 +: 32] = exp_w[3];
                #1;
                chk("h3_live_data", 256'(mem_acc_write_data), 256'(exp_w[3]));
            end
            tick();
            chk($sformatf("h%0d_hold", i),
                256'({dut.curr_state, mem_acc_write_addr, mem_acc_write_data}),
                256'({4'(5 + i), 16'(16'h5008 + 32 * i), exp_w[i]}));
            mem_acc_write_done = 1'b1;
            tick();
            mem_acc_write_done = 1'b0;
        end

        chk("done_state", 256'(dut.curr_state), 256'(WRITE_DONE_BIT));
        chk("done_wr", 256'({mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data}),
            256'({1'b1, 16'h5000, 32'h2}));
        mem_acc_write_done = 1'b1;
        tick();
        mem_acc_write_done = 1'b0;
        chk_quiet("back_idle");

        // Reset in the middle of HASH
        trigger_to_hash();
        chk("hash2_state", 256'(dut.curr_state), 256'(HASH));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_quiet("mid_reset");
        tick();
        chk("mid_reset_stay", 256'(dut.curr_state), 256'(IDLE));

        // Counter restarts cleanly after the aborted run
        trigger_to_hash();
        hash_cycles = 0;
        while ((dut.curr_state == HASH) && (hash_cycles < 200)) begin
            hash_cycles++;
            tick();
        end
        chk("hash2_dwell", 256'(hash_cycles), 256'(65));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
